// File: rtl/evm_pkg.sv
// Shared types and default sizing for the voting-machine blocks.
// The ballot-control state enum lives here so every block agrees on the encoding.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } vote_state_t;

    localparam int NUM_CAND_DEFAULT    = 4;
    localparam int CNT_W_DEFAULT       = 16;
    localparam int HOLD_CYCLES_DEFAULT = 8;

endpackage

// File: rtl/vote_counter.sv
// Saturating tally counter: counts enabled increments and sticks at all-ones.
// Used once per candidate and once more for the running total.
module vote_counter
    import evm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/vote_logger.sv
// Ballot control and tally: arms one ballot per officer release, records at most one
// vote per ballot into saturating counters, and exposes the tallies in result mode.
module vote_logger
    import evm_pkg::*;
#(
    parameter int  NUM_CAND    = NUM_CAND_DEFAULT,
    parameter int  CNT_W       = CNT_W_DEFAULT,
    parameter int  HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    localparam int SEL_W       = $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ballot_release,
    input  logic [NUM_CAND-1:0] valid_vote,
    input  logic                mode,
    input  logic [SEL_W-1:0]    result_sel,
    output logic                ballot_ready,
    output logic                vote_ack,
    output logic                invalid_vote,
    output logic [CNT_W-1:0]    result_count,
    output logic [CNT_W-1:0]    total_votes
);

    localparam int                  HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [NUM_CAND-1:0] VOTE_ONE  = NUM_CAND'(1);
    localparam int                  SEL_SLOTS = 1 << SEL_W;

    vote_state_t       state;
    vote_state_t       next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_next;

    logic any_vote;
    logic multi_vote;
    logic accept;
    logic ack_next;
    logic invalid_next;
    logic ready_next;

    logic [CNT_W-1:0] cand_count [SEL_SLOTS];
    logic [CNT_W-1:0] total_count;

    // Clearing the lowest set bit leaves something behind only when two or more bits are set.
    assign any_vote   = |valid_vote;
    assign multi_vote = |(valid_vote & (valid_vote - VOTE_ONE));
    assign accept     = (state == ARMED) && !mode && any_vote && !multi_vote;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            ballot_ready <= 1'b0;
            vote_ack     <= 1'b0;
            invalid_vote <= 1'b0;
        end else begin
            state        <= next_state;
            hold_cnt     <= hold_cnt_next;
            ballot_ready <= ready_next;
            vote_ack     <= ack_next;
            invalid_vote <= invalid_next;
        end
    end

    // Result mode overrides everything and drops any armed ballot or pending lockout.
    always_comb begin
        next_state    = state;
        hold_cnt_next = hold_cnt;
        if (mode) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ballot_release) begin
                        next_state = ARMED;
                    end
                end
                ARMED: begin
                    if (accept) begin
                        next_state    = HOLD;
                        hold_cnt_next = HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        next_state = IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt - HOLD_ONE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ack_next     = accept;
        invalid_next = 1'b0;
        ready_next   = (next_state == ARMED);
        if (!mode) begin
            case (state)
                IDLE, HOLD: invalid_next = any_vote;
                ARMED:      invalid_next = multi_vote;
                default:    invalid_next = 1'b0;
            endcase
        end
    end

    // Unused select codes map to a constant-zero slot so readout needs no range check.
    for (genvar i = 0; i < SEL_SLOTS; i++) begin : g_cand
        if (i < NUM_CAND) begin : g_real
            vote_counter #(
                .CNT_W (CNT_W)
            ) u_cand_counter (
                .clock (clock),
                .reset (reset),
                .inc   (accept && valid_vote[i]),
                .count (cand_count[i])
            );
        end else begin : g_pad
            assign cand_count[i] = '0;
        end
    end

    vote_counter #(
        .CNT_W (CNT_W)
    ) u_total_counter (
        .clock (clock),
        .reset (reset),
        .inc   (accept),
        .count (total_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_count <= '0;
            total_votes  <= '0;
        end else if (mode) begin
            result_count <= cand_count[result_sel];
            total_votes  <= total_count;
        end else begin
            result_count <= '0;
            total_votes  <= '0;
        end
    end

endmodule

// File: tb/tb_vote_logger.sv
// Randomized and directed bench for vote_logger against a cycle-level behavioural model.
// A narrow-counter instance exercises saturation; a default-width twin shares its inputs.
module tb_vote_logger;

    localparam int NUM_CAND    = 4;
    localparam int CNT_W       = 4;
    localparam int HOLD_CYCLES = 8;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_HOLD  = 2;

    logic       clock          = 1'b0;
    logic       reset          = 1'b0;
    logic       ballot_release = 1'b0;
    logic [3:0] valid_vote     = 4'b0000;
    logic       mode           = 1'b0;
    logic [1:0] result_sel     = 2'd0;

    logic             ballot_ready;
    logic             vote_ack;
    logic             invalid_vote;
    logic [CNT_W-1:0] result_count;
    logic [CNT_W-1:0] total_votes;

    logic        ballot_ready16;
    logic        vote_ack16;
    logic        invalid_vote16;
    logic [15:0] result_count16;
    logic [15:0] total_votes16;

    int errors = 0;
    int checks = 0;

    int   m_phase;
    int   m_hold;
    int   m_cnt [NUM_CAND];
    int   m_total;
    logic e_ack;
    logic e_inv;
    logic e_ready;
    int   e_rc;
    int   e_tot;
    int   e_rc16;
    int   e_tot16;

    vote_logger #(
        .NUM_CAND    (NUM_CAND),
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ballot_release (ballot_release),
        .valid_vote     (valid_vote),
        .mode           (mode),
        .result_sel     (result_sel),
        .ballot_ready   (ballot_ready),
        .vote_ack       (vote_ack),
        .invalid_vote   (invalid_vote),
        .result_count   (result_count),
        .total_votes    (total_votes)
    );

    vote_logger #(
        .NUM_CAND    (NUM_CAND),
        .CNT_W       (16),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) dut16 (
        .clock          (clock),
        .reset          (reset),
        .ballot_release (ballot_release),
        .valid_vote     (valid_vote),
        .mode           (mode),
        .result_sel     (result_sel),
        .ballot_ready   (ballot_ready16),
        .vote_ack       (vote_ack16),
        .invalid_vote   (invalid_vote16),
        .result_count   (result_count16),
        .total_votes    (total_votes16)
    );

    always #5 clock = ~clock;

    function automatic int sat(input int value, input int width);
        int limit;
        limit = (1 << width) - 1;
        return (value > limit) ? limit : value;
    endfunction

    task automatic model_clear();
        m_phase = P_IDLE;
        m_hold  = 0;
        m_total = 0;
        for (int i = 0; i < NUM_CAND; i++) m_cnt[i] = 0;
    endtask

    // One clock: drive inputs, let the edge happen, then advance the model by the same edge.
    task automatic step(input logic rel, input logic [3:0] vote, input logic md, input logic [1:0] sel);
        int n;
        int idx;
        ballot_release = rel;
        valid_vote     = vote;
        mode           = md;
        result_sel     = sel;
        @(posedge clock);
        #1;
        n     = $countones(vote);
        idx   = 0;
        for (int i = 0; i < NUM_CAND; i++) if (vote[i]) idx = i;
        e_ack = 1'b0;
        e_inv = 1'b0;
        if (md) begin
            e_rc    = (int'(sel) < NUM_CAND) ? sat(m_cnt[sel], CNT_W) : 0;
            e_rc16  = (int'(sel) < NUM_CAND) ? sat(m_cnt[sel], 16) : 0;
            e_tot   = sat(m_total, CNT_W);
            e_tot16 = sat(m_total, 16);
            m_phase = P_IDLE;
        end else begin
            e_rc = 0; e_rc16 = 0; e_tot = 0; e_tot16 = 0;
            if (m_phase == P_IDLE) begin
                e_inv = (n > 0);
                if (rel) m_phase = P_ARMED;
            end else if (m_phase == P_ARMED) begin
                if (n == 1) begin
                    m_cnt[idx]++;
                    m_total++;
                    e_ack   = 1'b1;
                    m_phase = P_HOLD;
                    m_hold  = HOLD_CYCLES;
                end else if (n > 1) begin
                    e_inv = 1'b1;
                end
            end else begin
                e_inv = (n > 0);
                m_hold--;
                if (m_hold == 0) m_phase = P_IDLE;
            end
        end
        e_ready        = (m_phase == P_ARMED);
        ballot_release = 1'b0;
        valid_vote     = 4'b0000;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        ballot_release = 1'b0;
        valid_vote     = 4'b0000;
        mode           = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        ballot_release = 1'b1;
        valid_vote     = 4'b0001;
        mode           = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({ballot_ready, vote_ack, invalid_vote} !== 3'b000 || result_count !== '0 || total_votes !== '0)
            begin errors++; $display("[TB] FAIL reset_values: got rdy/ack/inv=%b%b%b rc=%0d tot=%0d expected all 0",
                ballot_ready, vote_ack, invalid_vote, result_count, total_votes); end
        ballot_release = 1'b0;
        valid_vote     = 4'b0000;
        mode           = 1'b0;
        reset          = 1'b1;
        model_clear();
        step(0, 4'b0000, 1, 2'd0);
        checks++;
        if (total_votes !== '0 || result_count !== '0)
            begin errors++; $display("[TB] FAIL reset_result: got rc=%0d tot=%0d expected 0/0", result_count, total_votes); end
    endtask

    task automatic test_basic_vote();
        do_reset();
        step(0, 4'b0000, 0, 2'd0);
        step(1, 4'b0000, 0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ballot_ready !== 1'b1)
                begin errors++; $display("[TB] FAIL basic_ready[%0d]: got %b expected 1", i, ballot_ready); end
            step(0, (i == 2) ? 4'b0100 : 4'b0000, 0, 2'd0);
        end
        checks++;
        if (vote_ack !== 1'b1 || ballot_ready !== 1'b0 || invalid_vote !== 1'b0)
            begin errors++; $display("[TB] FAIL basic_ack: got ack/rdy/inv=%b%b%b expected 100", vote_ack, ballot_ready, invalid_vote); end
        step(0, 4'b0000, 0, 2'd0);
        checks++;
        if (vote_ack !== 1'b0)
            begin errors++; $display("[TB] FAIL basic_ack_pulse: got %b expected 0", vote_ack); end
        step(0, 4'b0000, 1, 2'd2);
        checks++;
        if (result_count !== 4'd1 || total_votes !== 4'd1)
            begin errors++; $display("[TB] FAIL basic_result: got rc=%0d tot=%0d expected 1/1", result_count, total_votes); end
    endtask

    task automatic test_multi_hot();
        do_reset();
        step(1, 4'b0000, 0, 2'd0);
        step(0, 4'b0011, 0, 2'd0);
        checks++;
        if (invalid_vote !== 1'b1 || vote_ack !== 1'b0 || ballot_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL multi_reject: got inv/ack/rdy=%b%b%b expected 101", invalid_vote, vote_ack, ballot_ready); end
        step(0, 4'b0000, 0, 2'd0);
        checks++;
        if (invalid_vote !== 1'b0 || ballot_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL multi_pulse: got inv/rdy=%b%b expected 01", invalid_vote, ballot_ready); end
        step(0, 4'b0001, 0, 2'd0);
        checks++;
        if (vote_ack !== 1'b1)
            begin errors++; $display("[TB] FAIL multi_then_single: got ack=%b expected 1", vote_ack); end
        step(0, 4'b0000, 1, 2'd0);
        step(0, 4'b0000, 1, 2'd1);
        checks++;
        if (result_count !== 4'd0 || total_votes !== 4'd1)
            begin errors++; $display("[TB] FAIL multi_counts: got rc1=%0d tot=%0d expected 0/1", result_count, total_votes); end
    endtask

    task automatic test_idle_hold();
        do_reset();
        step(0, 4'b0010, 0, 2'd0);
        checks++;
        if (invalid_vote !== 1'b1 || ballot_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL idle_invalid: got inv/rdy=%b%b expected 10", invalid_vote, ballot_ready); end
        step(1, 4'b0000, 0, 2'd0);
        step(0, 4'b1000, 0, 2'd0);
        checks++;
        if (vote_ack !== 1'b1)
            begin errors++; $display("[TB] FAIL hold_entry_ack: got %b expected 1", vote_ack); end
        for (int k = 1; k <= HOLD_CYCLES + 1; k++) begin
            step((k == 3) || (k == HOLD_CYCLES) || (k == HOLD_CYCLES + 1), (k == 2) ? 4'b0100 : 4'b0000, 0, 2'd0);
            checks++;
            if (invalid_vote !== (k == 2) || ballot_ready !== (k == HOLD_CYCLES + 1) || vote_ack !== 1'b0)
                begin errors++; $display("[TB] FAIL hold_cycle[%0d]: got inv/rdy/ack=%b%b%b expected %b%b0",
                    k, invalid_vote, ballot_ready, vote_ack, (k == 2), (k == HOLD_CYCLES + 1)); end
        end
    endtask

    task automatic test_saturation();
        int   acks;
        logic last_ack;
        do_reset();
        acks     = 0;
        last_ack = 1'b0;
        for (int b = 0; b < 17; b++) begin
            step(1, 4'b0000, 0, 2'd0);
            step(0, 4'b0001, 0, 2'd0);
            if (vote_ack === 1'b1) acks++;
            if (b == 16) last_ack = vote_ack;
            repeat (HOLD_CYCLES) step(0, 4'b0000, 0, 2'd0);
        end
        checks++;
        if (last_ack !== 1'b1)
            begin errors++; $display("[TB] FAIL sat_17th_ack: got %b expected 1", last_ack); end
        checks++;
        if (acks != 17)
            begin errors++; $display("[TB] FAIL sat_ack_count: got %0d expected 17", acks); end
        step(0, 4'b0000, 1, 2'd0);
        checks++;
        if (result_count !== 4'd15 || total_votes !== 4'd15)
            begin errors++; $display("[TB] FAIL sat_result: got rc=%0d tot=%0d expected 15/15", result_count, total_votes); end
        checks++;
        if (result_count16 !== 16'd17 || total_votes16 !== 16'd17)
            begin errors++; $display("[TB] FAIL wide_result: got rc=%0d tot=%0d expected 17/17", result_count16, total_votes16); end
    endtask

    task automatic test_mode_discard();
        do_reset();
        step(1, 4'b0000, 0, 2'd0);
        checks++;
        if (ballot_ready !== 1'b1)
            begin errors++; $display("[TB] FAIL discard_armed: got %b expected 1", ballot_ready); end
        step(0, 4'b0001, 1, 2'd0);
        checks++;
        if (ballot_ready !== 1'b0 || vote_ack !== 1'b0 || invalid_vote !== 1'b0 || total_votes !== 4'd0)
            begin errors++; $display("[TB] FAIL discard_ignore: got rdy/ack/inv=%b%b%b tot=%0d expected 000 0",
                ballot_ready, vote_ack, invalid_vote, total_votes); end
        step(0, 4'b0000, 0, 2'd0);
        checks++;
        if (ballot_ready !== 1'b0)
            begin errors++; $display("[TB] FAIL discard_stays_idle: got %b expected 0", ballot_ready); end
        step(1, 4'b0000, 0, 2'd0);
        step(0, 4'b0010, 0, 2'd0);
        checks++;
        if (vote_ack !== 1'b1)
            begin errors++; $display("[TB] FAIL discard_rearm_vote: got ack=%b expected 1", vote_ack); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            step(1, 4'b0000, 0, 2'd0);
            step(0, 4'(1 << b), 0, 2'd0);
            if (b < 2) repeat (HOLD_CYCLES) step(0, 4'b0000, 0, 2'd0);
        end
        repeat (2) step(0, 4'b0000, 0, 2'd0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({ballot_ready, vote_ack, invalid_vote} !== 3'b000 || result_count !== '0 || total_votes !== '0
            || result_count16 !== '0 || total_votes16 !== '0)
            begin errors++; $display("[TB] FAIL midhold_reset: got rdy/ack/inv=%b%b%b rc=%0d tot=%0d expected all 0",
                ballot_ready, vote_ack, invalid_vote, result_count, total_votes); end
        reset = 1'b1;
        model_clear();
        step(0, 4'b0000, 1, 2'd1);
        checks++;
        if (total_votes !== 4'd0 || result_count !== 4'd0 || total_votes16 !== 16'd0)
            begin errors++; $display("[TB] FAIL midhold_tallies: got tot=%0d rc=%0d expected 0/0", total_votes, result_count); end
    endtask

    task automatic test_random();
        logic       rel;
        logic [3:0] vote;
        logic       md;
        logic [1:0] sel;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rel  = ($urandom_range(0, 2) == 0);
            vote = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            md   = ($urandom_range(0, 6) == 0);
            sel  = 2'($urandom_range(0, 3));
            step(rel, vote, md, sel);
            checks++;
            if (vote_ack !== e_ack || invalid_vote !== e_inv || ballot_ready !== e_ready
                || result_count !== 4'(e_rc) || total_votes !== 4'(e_tot))
                begin errors++; $display("[TB] FAIL random[%0d]: got ack/inv/rdy=%b%b%b rc=%0d tot=%0d expected %b%b%b rc=%0d tot=%0d",
                    c, vote_ack, invalid_vote, ballot_ready, result_count, total_votes, e_ack, e_inv, e_ready, e_rc, e_tot); end
            checks++;
            if (vote_ack16 !== e_ack || invalid_vote16 !== e_inv || ballot_ready16 !== e_ready
                || result_count16 !== 16'(e_rc16) || total_votes16 !== 16'(e_tot16))
                begin errors++; $display("[TB] FAIL random_wide[%0d]: got ack/inv/rdy=%b%b%b rc=%0d tot=%0d expected %b%b%b rc=%0d tot=%0d",
                    c, vote_ack16, invalid_vote16, ballot_ready16, result_count16, total_votes16, e_ack, e_inv, e_ready, e_rc16, e_tot16); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic_vote();
        test_multi_hot();
        test_idle_hold();
        test_saturation();
        test_mode_discard();
        test_reset_mid_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
